// File: rtl/midi_tx_framer.sv
// midi_tx_framer: serialises one MIDI message (status + up to two data bytes)
// per handshake onto the DIN-out line as 8N1 UART frames. An internal baud
// divider replaces the old free-running baud clock, and channel status bytes
// may optionally be suppressed with MIDI running status.
module midi_tx_framer #(
  parameter int BAUD_CNT       = 3200,  // clk cycles per bit, >= 2
  parameter bit RUNNING_STATUS = 1'b0   // 1 = omit repeated channel status
) (
  input  logic       clk,
  input  logic       rst,         // asynchronous, active low
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] status_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  input  logic [1:0] byte_cnt_i,
  output logic       midi_tx,
  output logic       busy,
  output logic       done
);

  localparam int              BW        = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_CNT - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    status_q;
  logic [7:0]    data1_q;
  logic [7:0]    data2_q;
  logic [1:0]    cnt_q;
  logic [1:0]    idx_q;          // index of the next byte to load (0=status)
  logic [7:0]    last_status_q;
  logic          last_vld_q;
  logic          tx_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]    idx_start_d;
  logic [7:0]    load_byte_d;
  logic          bit_end_d;

  // First byte index of a new message: start at data1 when the status byte
  // repeats the running status of a channel message with data.
  always_comb begin
    idx_start_d = 2'd0;
    if ((RUNNING_STATUS != 1'b0) && (byte_cnt_i >= 2'd2) && last_vld_q &&
        (status_i == last_status_q)) begin
      idx_start_d = 2'd1;
    end else begin
      idx_start_d = 2'd0;
    end
  end

  // Byte picked up in LOAD, in status/data1/data2 order.
  always_comb begin
    load_byte_d = 8'h00;
    case (idx_q)
      2'd0:    load_byte_d = status_q;
      2'd1:    load_byte_d = data1_q;
      default: load_byte_d = data2_q;
    endcase
  end

  // Last clock of the current bit period.
  always_comb begin
    bit_end_d = 1'b0;
    if (baud_q == BAUD_LAST) begin
      bit_end_d = 1'b1;
    end else begin
      bit_end_d = 1'b0;
    end
  end

  // Framing FSM with registered line, handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      status_q      <= 8'h00;
      data1_q       <= 8'h00;
      data2_q       <= 8'h00;
      cnt_q         <= 2'd0;
      idx_q         <= 2'd0;
      last_status_q <= 8'h00;
      last_vld_q    <= 1'b0;
      tx_q          <= 1'b1;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd_valid && ready_q) begin
            status_q <= status_i;
            data1_q  <= data1_i;
            data2_q  <= data2_i;
            cnt_q    <= byte_cnt_i;
            idx_q    <= idx_start_d;
            ready_q  <= 1'b0;
            // an empty message never shows busy
            busy_q   <= (byte_cnt_i != 2'd0);
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          baud_q <= '0;
          if (idx_q < cnt_q) begin
            shift_q <= load_byte_d;
            idx_q   <= idx_q + 2'd1;
            tx_q    <= 1'b0;
            state_q <= S_START;
            // track running status as the status byte goes out
            if ((RUNNING_STATUS != 1'b0) && (idx_q == 2'd0)) begin
              if ((status_q >= 8'h80) && (status_q <= 8'hEF)) begin
                last_status_q <= status_q;
                last_vld_q    <= 1'b1;
              end else if ((status_q >= 8'hF0) && (status_q <= 8'hF7)) begin
                last_vld_q    <= 1'b0;
              end else begin
                last_vld_q    <= last_vld_q;
              end
            end
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_START: begin
          if (bit_end_d) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= S_DATA;
          end else begin
            baud_q  <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (bit_end_d) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (bit_end_d) begin
            baud_q <= '0;
            if (idx_q < cnt_q) begin
              state_q <= S_LOAD;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign midi_tx   = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_midi_tx_framer.sv
// Scoreboard bench for midi_tx_framer (BAUD_CNT=4). Instance u0 has running
// status off, u1 has it on. The driver pushes expected bytes (with the cycle
// their start bit must appear) and expected done cycles; line and done
// monitors decode the DUT outputs and pop/compare independently.
module tb_midi_tx_framer;

  localparam int B = 4;

  typedef struct packed {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_w, valid_w, ready_w, tx_w, busy_w, done_w;
  logic [7:0] st_w [2];
  logic [7:0] d1_w [2];
  logic [7:0] d2_w [2];
  logic [1:0] cnt_w [2];

  midi_tx_framer #(.BAUD_CNT(B), .RUNNING_STATUS(1'b0)) u0 (
    .clk(clk), .rst(rst_w[0]), .cmd_valid(valid_w[0]), .cmd_ready(ready_w[0]),
    .status_i(st_w[0]), .data1_i(d1_w[0]), .data2_i(d2_w[0]), .byte_cnt_i(cnt_w[0]),
    .midi_tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  midi_tx_framer #(.BAUD_CNT(B), .RUNNING_STATUS(1'b1)) u1 (
    .clk(clk), .rst(rst_w[1]), .cmd_valid(valid_w[1]), .cmd_ready(ready_w[1]),
    .status_i(st_w[1]), .data1_i(d1_w[1]), .data2_i(d2_w[1]), .byte_cnt_i(cnt_w[1]),
    .midi_tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   epoch [2];
  exp_t bq0[$], bq1[$];
  int   dq0[$], dq1[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int bq_size(input int id);
    return (id == 0) ? bq0.size() : bq1.size();
  endfunction

  function automatic exp_t bq_pop(input int id);
    exp_t e;
    if (id == 0) e = bq0.pop_front();
    else         e = bq1.pop_front();
    return e;
  endfunction

  function automatic int dq_size(input int id);
    return (id == 0) ? dq0.size() : dq1.size();
  endfunction

  function automatic int dq_pop(input int id);
    int v;
    if (id == 0) v = dq0.pop_front();
    else         v = dq1.pop_front();
    return v;
  endfunction

  // Issue one message at a negedge; records the cycle index of the accept.
  task automatic send(input int id, input logic [7:0] st, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [1:0] cnt, input int n,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                      input bit keep, output int acc);
    logic [7:0] eb [3];
    exp_t       e;
    bit         got;
    eb = '{e0, e1, e2};
    st_w[id]    = st;
    d1_w[id]    = d1;
    d2_w[id]    = d2;
    cnt_w[id]   = cnt;
    valid_w[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (ready_w[id]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", int'(ready_w[id]), 1);
      valid_w[id] = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      for (int k = 0; k < n; k++) begin
        e.b = eb[k];
        e.t = acc + 2 + 41 * k;
        if (id == 0) bq0.push_back(e);
        else         bq1.push_back(e);
      end
      if (id == 0) dq0.push_back((n == 0) ? acc + 2 : acc + 1 + 41 * n);
      else         dq1.push_back((n == 0) ? acc + 2 : acc + 1 + 41 * n);
      @(negedge clk);
      chk("ready_after_accept", int'(ready_w[id]), 0);
      chk("busy_in_load", int'(busy_w[id]), (n > 0) ? 1 : 0);
      if (!keep) valid_w[id] = 1'b0;
    end
  endtask

  // Line monitor: decodes 8N1 frames, compares byte and start cycle.
  task automatic mon_line(input int id);
    forever begin
      @(negedge clk);
      if (rst_w[id] && (tx_w[id] == 1'b0)) begin
        int         t;
        int         ep;
        logic [7:0] d;
        logic       st_ok;
        exp_t       e;
        t  = cyc;
        ep = epoch[id];
        @(negedge clk);
        st_ok = (tx_w[id] == 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (B) @(negedge clk);
          d[b] = tx_w[id];
        end
        repeat (B) @(negedge clk);
        if (ep == epoch[id]) begin
          chk("start_bit_width", int'(st_ok), 1);
          chk("stop_bit", int'(tx_w[id]), 1);
          if (bq_size(id) == 0) begin
            chk("unexpected_frame_pending", bq_size(id), 1);
          end else begin
            e = bq_pop(id);
            chk("frame_byte", int'(d), int'(e.b));
            chk("frame_start_cycle", t, e.t);
          end
        end
      end
    end
  endtask

  // Done monitor: every pulse must match one expected cycle.
  task automatic mon_done(input int id);
    forever begin
      @(negedge clk);
      if (done_w[id]) begin
        if (dq_size(id) == 0) chk("unexpected_done_pending", dq_size(id), 1);
        else                  chk("done_cycle", cyc, dq_pop(id));
      end
    end
  endtask

  initial mon_line(0);
  initial mon_line(1);
  initial mon_done(0);
  initial mon_done(1);

  int a0, a1, a2, bcnt;

  initial begin
    epoch[0] = 0;
    epoch[1] = 0;
    rst_w    = 2'b00;
    valid_w  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      st_w[i] = 8'h00; d1_w[i] = 8'h00; d2_w[i] = 8'h00; cnt_w[i] = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_tx", int'(tx_w[i]), 1);
      chk("reset_ready", int'(ready_w[i]), 1);
      chk("reset_busy", int'(busy_w[i]), 0);
      chk("reset_done", int'(done_w[i]), 0);
    end
    rst_w = 2'b11;
    @(negedge clk);

    // running status off: full 3-byte message
    send(0, 8'hB0, 8'h2E, 8'h7F, 2'd3, 3, 8'hB0, 8'h2E, 8'h7F, 1'b0, a0);
    // cmd_valid held across two messages
    send(0, 8'h90, 8'h3C, 8'h64, 2'd3, 3, 8'h90, 8'h3C, 8'h64, 1'b1, a1);
    send(0, 8'h80, 8'h3C, 8'h00, 2'd3, 3, 8'h80, 8'h3C, 8'h00, 1'b0, a2);
    chk("b2b_accept_cycle", a2, a1 + 125);
    // empty message
    send(0, 8'h90, 8'h11, 8'h22, 2'd0, 0, 8'h00, 8'h00, 8'h00, 1'b0, a0);
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_w[0]) bcnt++;
      @(negedge clk);
    end
    chk("busy_cnt0_cycles", bcnt, 0);
    // single byte and repeated status without compression
    send(0, 8'hF8, 8'h00, 8'h00, 2'd1, 1, 8'hF8, 8'h00, 8'h00, 1'b0, a0);
    send(0, 8'hC0, 8'h42, 8'h00, 2'd2, 2, 8'hC0, 8'h42, 8'h00, 1'b0, a0);
    send(0, 8'hC0, 8'h43, 8'h00, 2'd2, 2, 8'hC0, 8'h43, 8'h00, 1'b0, a0);

    // running status on
    send(1, 8'hC0, 8'h42, 8'h00, 2'd2, 2, 8'hC0, 8'h42, 8'h00, 1'b0, a0);
    send(1, 8'hC0, 8'h43, 8'h00, 2'd2, 1, 8'h43, 8'h00, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h2E, 8'h7F, 2'd3, 3, 8'hB0, 8'h2E, 8'h7F, 1'b0, a0);
    send(1, 8'hF8, 8'h00, 8'h00, 2'd1, 1, 8'hF8, 8'h00, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h2E, 8'h00, 2'd3, 2, 8'h2E, 8'h00, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h2E, 8'h7F, 2'd3, 2, 8'h2E, 8'h7F, 8'h00, 1'b0, a0);
    send(1, 8'hF0, 8'h00, 8'h00, 2'd1, 1, 8'hF0, 8'h00, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h2E, 8'h00, 2'd3, 3, 8'hB0, 8'h2E, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h00, 8'h00, 2'd1, 1, 8'hB0, 8'h00, 8'h00, 1'b0, a0);
    send(1, 8'hB0, 8'h01, 8'h02, 2'd2, 1, 8'h01, 8'h00, 8'h00, 1'b0, a0);

    // reset in the middle of a data bit on u0
    send(0, 8'hB0, 8'h2E, 8'h7F, 2'd3, 3, 8'hB0, 8'h2E, 8'h7F, 1'b0, a0);
    repeat (10) @(negedge clk);
    chk("tx_low_before_reset", int'(tx_w[0]), 0);
    #2;
    rst_w[0] = 1'b0;
    epoch[0]++;
    #1;
    chk("async_reset_tx", int'(tx_w[0]), 1);
    chk("async_reset_busy", int'(busy_w[0]), 0);
    chk("async_reset_ready", int'(ready_w[0]), 1);
    chk("async_reset_done", int'(done_w[0]), 0);
    bq0.delete();
    dq0.delete();
    @(negedge clk);
    rst_w[0] = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", int'(ready_w[0]), 1);
    chk("post_reset_busy", int'(busy_w[0]), 0);
    chk("post_reset_tx", int'(tx_w[0]), 1);
    repeat (50) @(negedge clk);
    send(0, 8'h55, 8'hAA, 8'h00, 2'd2, 2, 8'h55, 8'hAA, 8'h00, 1'b0, a0);

    // drain outstanding expectations
    for (int i = 0; i < 3000 && (bq0.size() + bq1.size() + dq0.size() + dq1.size()) > 0; i++)
      @(negedge clk);
    chk("scoreboard_drained", bq0.size() + bq1.size() + dq0.size() + dq1.size(), 0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
